// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - instruction-fetch sequencer owning the PC register and pc_mux select
// Optional breakpoint compare enabled by macro PC_BREAKPOINT_EN.
module pc_fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run,
    input  logic        halt_req,
    input  logic [15:0] pc_next,
    output logic [1:0]  pc_select,
    output logic        ld_pc,
    output logic [15:0] pc,
    output logic        ld_mar,
    output logic        mem_oe,
    input  logic        mem_rdy,
    input  logic [15:0] mem_data,
    output logic        ld_ir,
    output logic [15:0] ir,
    input  logic        exec_done,
    input  logic        redirect,
    input  logic        redirect_src,
    output logic        fault,
    output logic [2:0]  state_dbg
`ifdef PC_BREAKPOINT_EN
    ,
    input  logic [15:0] bp_addr,
    input  logic        bp_arm,
    output logic        bp_hit
`endif
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_F1    = 3'd1,
        S_F2    = 3'd2,
        S_F3    = 3'd3,
        S_EX    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       fault_q;
    logic       bp_stop;

`ifdef PC_BREAKPOINT_EN
    logic skip;
    // Skip flag lets the run after a breakpoint fetch the matching address once.
    assign bp_stop = bp_arm && (pc == bp_addr) && !skip;
    assign bp_hit  = (state == S_F1) && bp_stop && !Reset;
`else
    assign bp_stop = 1'b0;
`endif

    assign fault     = fault_q;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        pc_select = 2'b00;
        ld_pc     = 1'b0;
        ld_mar    = 1'b0;
        mem_oe    = 1'b0;
        ld_ir     = 1'b0;
        case (state)
            S_HALT: if (run) state_nxt = S_F1;
            S_F1: begin
                if (bp_stop) begin
                    state_nxt = S_HALT;
                end else begin
                    ld_mar    = 1'b1;
                    ld_pc     = 1'b1;
                    state_nxt = S_F2;
                end
            end
            S_F2: begin
                mem_oe = 1'b1;
                if (mem_rdy)                    state_nxt = S_F3;
                else if (wait_cnt == LAST_WAIT) state_nxt = S_FAULT;
            end
            S_F3: begin
                ld_ir     = 1'b1;
                state_nxt = S_EX;
            end
            S_EX: begin
                if (exec_done) begin
                    if (redirect) begin
                        pc_select = redirect_src ? 2'b10 : 2'b01;
                        ld_pc     = 1'b1;
                    end
                    state_nxt = halt_req ? S_HALT : S_F1;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_HALT;
        endcase
        // Strobes must be quiet while Reset is held, whatever state is registered.
        if (Reset) begin
            pc_select = 2'b00;
            ld_pc     = 1'b0;
            ld_mar    = 1'b0;
            mem_oe    = 1'b0;
            ld_ir     = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_HALT;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            fault_q  <= 1'b0;
            wait_cnt <= 8'd0;
`ifdef PC_BREAKPOINT_EN
            skip     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (ld_pc) pc <= pc_next;
            if (state == S_F1) wait_cnt <= 8'd0;
            if (state == S_F2) begin
                if (mem_rdy) ir <= mem_data;
                else         wait_cnt <= wait_cnt + 8'd1;
            end
            if (state_nxt == S_FAULT) fault_q <= 1'b1;
`ifdef PC_BREAKPOINT_EN
            if (state == S_F1) skip <= bp_stop;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - scoreboard bench for pc_fetch_seq
// Covers PC_BREAKPOINT_EN when that macro is defined.
module tb_pc_fetch_seq;

    localparam logic [2:0] ST_HALT = 3'd0, ST_F1 = 3'd1, ST_F2 = 3'd2;
    localparam logic [2:0] ST_F3 = 3'd3, ST_EX = 3'd4, ST_FAULT = 3'd5;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] pc_next;
    logic [1:0]  pc_select;
    logic        ld_pc;
    logic [15:0] pc;
    logic        ld_mar;
    logic        mem_oe;
    logic        mem_rdy = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        ld_ir;
    logic [15:0] ir;
    logic        exec_done = 1'b0;
    logic        redirect = 1'b0;
    logic        redirect_src = 1'b0;
    logic        fault;
    logic [2:0]  state_dbg;
    logic [15:0] bus_val = 16'h0000;
    logic [15:0] adder_val = 16'h0000;
`ifdef PC_BREAKPOINT_EN
    logic [15:0] bp_addr = 16'h0000;
    logic        bp_arm = 1'b0;
    logic        bp_hit;
`endif

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_pc_q[$];
    logic [15:0] exp_ir_q[$];

    always #5 Clk = ~Clk;

    // External pc_mux: 00 PC+1, 01 bus, 10 adder.
    assign pc_next = (pc_select == 2'b00) ? pc + 16'd1 :
                     (pc_select == 2'b01) ? bus_val :
                     (pc_select == 2'b10) ? adder_val : 16'h0000;

    pc_fetch_seq #(.RESET_PC(16'h0000), .TIMEOUT(8)) dut (
        .Clk(Clk), .Reset(Reset), .run(run), .halt_req(halt_req),
        .pc_next(pc_next), .pc_select(pc_select), .ld_pc(ld_pc), .pc(pc),
        .ld_mar(ld_mar), .mem_oe(mem_oe), .mem_rdy(mem_rdy), .mem_data(mem_data),
        .ld_ir(ld_ir), .ir(ir), .exec_done(exec_done), .redirect(redirect),
        .redirect_src(redirect_src), .fault(fault), .state_dbg(state_dbg)
`ifdef PC_BREAKPOINT_EN
        , .bp_addr(bp_addr), .bp_arm(bp_arm), .bp_hit(bp_hit)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: pops scoreboard entries whenever the DUT strobes ld_ir or ld_pc.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge Clk);
            chk("select_not_11", {31'd0, pc_select == 2'b11}, 32'd0);
            if (ld_ir) begin
                if (exp_ir_q.size() == 0) chk("unexpected_ld_ir", 32'd1, 32'd0);
                else chk("ir_value", {16'd0, ir}, {16'd0, exp_ir_q.pop_front()});
            end
            if (ld_pc) begin
                if (exp_pc_q.size() == 0) begin
                    chk("unexpected_ld_pc", 32'd1, 32'd0);
                end else begin
                    e = exp_pc_q.pop_front();
                    chk("pc_select", {30'd0, pc_select}, {30'd0, e[17:16]});
                    @(posedge Clk);
                    #1;
                    chk("pc_loaded", {16'd0, pc}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic start_fetch(input logic [15:0] next_pc);
        exp_pc_q.push_back({2'b00, next_pc});
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("enter_f1", {29'd0, state_dbg}, {29'd0, ST_F1});
    endtask

    // From F1: wait cycles in F2, then deliver data and land in EX.
    task automatic do_fetch(input logic [15:0] d, input int waits);
        tick();
        chk("f2_mem_oe", {31'd0, mem_oe}, 32'd1);
        repeat (waits) tick();
        mem_rdy = 1'b1;
        mem_data = d;
        exp_ir_q.push_back(d);
        tick();
        mem_rdy = 1'b0;
        chk("f3_state", {29'd0, state_dbg}, {29'd0, ST_F3});
        chk("f3_ld_ir", {31'd0, ld_ir}, 32'd1);
        tick();
        chk("ex_state", {29'd0, state_dbg}, {29'd0, ST_EX});
        chk("ex_ld_ir_low", {31'd0, ld_ir}, 32'd0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_state", {29'd0, state_dbg}, {29'd0, ST_HALT});
        chk("rst_pc", {16'd0, pc}, 32'h0);
        chk("rst_ir", {16'd0, ir}, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_strobes", {28'd0, ld_pc, ld_mar, mem_oe, ld_ir}, 32'd0);
        Reset = 1'b0;
        tick();

        // Fetch with two wait states
        start_fetch(16'h0001);
        chk("f1_ld_mar", {31'd0, ld_mar}, 32'd1);
        do_fetch(16'h1234, 2);
        chk("ir_1234", {16'd0, ir}, 32'h1234);

        // Jump from bus; redirect alone is ignored first
        bus_val = 16'h3000;
        redirect = 1'b1;
        #1;
        chk("redirect_no_done", {31'd0, ld_pc}, 32'd0);
        exec_done = 1'b1;
        exp_pc_q.push_back({2'b01, 16'h3000});
        #1;
        chk("jump_select", {30'd0, pc_select}, 32'd1);
        chk("jump_ld_pc", {31'd0, ld_pc}, 32'd1);
        tick();
        exec_done = 1'b0;
        redirect = 1'b0;
        chk("jump_pc", {16'd0, pc}, 32'h3000);
        chk("jump_f1_ld_mar", {31'd0, ld_mar}, 32'd1);
        exp_pc_q.push_back({2'b00, 16'h3001});
        do_fetch(16'hA5A5, 0);

        // Branch from adder
        adder_val = 16'h0042;
        redirect_src = 1'b1;
        redirect = 1'b1;
        exec_done = 1'b1;
        exp_pc_q.push_back({2'b10, 16'h0042});
        #1;
        chk("branch_select", {30'd0, pc_select}, 32'd2);
        tick();
        exec_done = 1'b0;
        redirect = 1'b0;
        redirect_src = 1'b0;
        chk("branch_pc", {16'd0, pc}, 32'h0042);
        exp_pc_q.push_back({2'b00, 16'h0043});
        do_fetch(16'h0BEE, 1);

        // Halt at exec_done with no redirect
        exec_done = 1'b1;
        halt_req = 1'b1;
        #1;
        chk("halt_no_ld_pc", {31'd0, ld_pc}, 32'd0);
        tick();
        exec_done = 1'b0;
        halt_req = 1'b0;
        chk("halt_state", {29'd0, state_dbg}, {29'd0, ST_HALT});
        chk("halt_pc", {16'd0, pc}, 32'h0043);
        chk("halt_no_ld_mar", {31'd0, ld_mar}, 32'd0);

        // Memory timeout: exactly 8 F2 cycles
        start_fetch(16'h0044);
        tick();
        n = 0;
        while (state_dbg == ST_F2 && n < 20) begin
            tick();
            n++;
        end
        chk("timeout_f2_cycles", n, 32'd8);
        chk("fault_state", {29'd0, state_dbg}, {29'd0, ST_FAULT});
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_mem_oe", {31'd0, mem_oe}, 32'd0);
        chk("fault_stays", {29'd0, state_dbg}, {29'd0, ST_FAULT});
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        chk("post_fault_state", {29'd0, state_dbg}, {29'd0, ST_HALT});

        // Reset mid-F2
        start_fetch(16'h0001);
        tick();
        tick();
        Reset = 1'b1;
        #1;
        chk("rst_f2_mem_oe", {31'd0, mem_oe}, 32'd0);
        tick();
        Reset = 1'b0;
        chk("rst_f2_state", {29'd0, state_dbg}, {29'd0, ST_HALT});
        chk("rst_f2_pc", {16'd0, pc}, 32'h0);
        chk("rst_f2_mem_oe_next", {31'd0, mem_oe}, 32'd0);

        // mem_rdy on the final count wins
        start_fetch(16'h0001);
        do_fetch(16'h7777, 7);
        exec_done = 1'b1;
        halt_req = 1'b1;
        tick();
        exec_done = 1'b0;
        halt_req = 1'b0;
        chk("last_rdy_no_fault", {31'd0, fault}, 32'd0);

`ifdef PC_BREAKPOINT_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bp_addr = 16'h0002;
        bp_arm = 1'b1;
        start_fetch(16'h0001);
        do_fetch(16'h1111, 0);
        exec_done = 1'b1;
        exp_pc_q.push_back({2'b00, 16'h0002});
        tick();
        exec_done = 1'b0;
        do_fetch(16'h2222, 0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("bp_hit", {31'd0, bp_hit}, 32'd1);
        chk("bp_no_ld_mar", {31'd0, ld_mar}, 32'd0);
        chk("bp_no_ld_pc", {31'd0, ld_pc}, 32'd0);
        tick();
        chk("bp_halt", {29'd0, state_dbg}, {29'd0, ST_HALT});
        chk("bp_pc", {16'd0, pc}, 32'h0002);
        chk("bp_hit_one_cycle", {31'd0, bp_hit}, 32'd0);
        start_fetch(16'h0003);
        chk("bp_skip_ld_mar", {31'd0, ld_mar}, 32'd1);
        tick();
        chk("bp_resume_pc", {16'd0, pc}, 32'h0003);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
`endif

        tick();
        tick();
        chk("pc_queue_empty", exp_pc_q.size(), 32'd0);
        chk("ir_queue_empty", exp_ir_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
